// File: rtl/ft_pkt_pkg.sv
// ft_pkt_pkg: shared FSM states, framing constants and helpers for the frame parser
package ft_pkt_pkg;
    typedef enum logic [2:0] {S_HUNT, S_ADDR, S_LEN, S_DATA, S_CHK, S_COMMIT} state_t;
    localparam logic [7:0] SYNC = 8'hA5;
    localparam int MAX_LEN_LIMIT = 16;
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return v == 8'hFF ? v : v + 8'd1;
    endfunction
endpackage

// File: rtl/ft_pkt_buf.sv
// ft_pkt_buf: payload register file, one write port, one read port with registered read data
//   clk/reset_n : clock, sync active-low reset (clears rdata only)
//   we/waddr/wdata : write port
//   re/raddr/rdata : read port; rdata updates only when re, otherwise holds
module ft_pkt_buf #(
    parameter int DEPTH = 16,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);
    logic [7:0] mem [DEPTH];
    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;
    always_ff @(posedge clk)
        if (!reset_n) rdata <= 8'd0;
        else if (re) rdata <= mem[raddr];
endmodule

// File: rtl/ft_pkt_parser.sv
// ft_pkt_parser: parses SYNC/ADDR/LEN/payload/CHK frames and replays payload as register writes
//   clk, reset_n (sync active-low); rx_data/rx_valid in, rx_ready out
//   wr_en/wr_addr/wr_data register-write port; pkt_ok/pkt_err/ovr pulses; err_cnt saturating
//   FT_PKT_TIMEOUT_EN: when defined, abort a frame after TIMEOUT_CYCLES idle cycles
module ft_pkt_parser
    import ft_pkt_pkg::*;
#(
    parameter int MAX_LEN = MAX_LEN_LIMIT,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_ready,
    output logic       wr_en,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       pkt_ok,
    output logic       pkt_err,
    output logic       ovr,
    output logic [7:0] err_cnt
);
    localparam int AW = MAX_LEN > 1 ? $clog2(MAX_LEN) : 1;
    state_t state;
    logic [7:0] addr, len, sum, idx;
    logic acc, chk_ok, last, rd_en, timeout;
    logic [AW-1:0] raddr;
    assign acc = rx_valid && rx_ready;
    assign chk_ok = rx_data == sum;
    assign last = idx == len - 8'd1;
    // Prefetch payload[0] on CHK acceptance so the first write lands the very next cycle
    assign rd_en = (state == S_CHK && acc && chk_ok && len != 8'd0) || (state == S_COMMIT && !last);
    assign raddr = state == S_COMMIT ? idx[AW-1:0] + AW'(1) : '0;
    // Dropped-byte flag must coincide with the offending strobe, so it is decoded from registered rx_ready
    assign ovr = rx_valid && !rx_ready;
`ifdef FT_PKT_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] idle_cnt;
    logic in_frame;
    assign in_frame = state == S_ADDR || state == S_LEN || state == S_DATA || state == S_CHK;
    always_ff @(posedge clk)
        if (!reset_n || acc || !in_frame) idle_cnt <= '0;
        else idle_cnt <= idle_cnt + 1'b1;
    assign timeout = in_frame && !acc && idle_cnt == TW'(TIMEOUT_CYCLES - 1);
`else
    assign timeout = 1'b0;
`endif
    ft_pkt_buf #(.DEPTH(MAX_LEN), .AW(AW)) u_buf (
        .clk(clk),
        .reset_n(reset_n),
        .we(acc && state == S_DATA),
        .waddr(idx[AW-1:0]),
        .wdata(rx_data),
        .re(rd_en),
        .raddr(raddr),
        .rdata(wr_data)
    );
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= S_HUNT;
            rx_ready <= 1'b1;
            wr_en <= 1'b0;
            pkt_ok <= 1'b0;
            pkt_err <= 1'b0;
            wr_addr <= 8'd0;
            err_cnt <= 8'd0;
            addr <= 8'd0;
            len <= 8'd0;
            sum <= 8'd0;
            idx <= 8'd0;
        end else begin
            wr_en <= 1'b0;
            pkt_ok <= 1'b0;
            pkt_err <= 1'b0;
            if (timeout) begin
                pkt_err <= 1'b1;
                err_cnt <= sat_inc(err_cnt);
                state <= S_HUNT;
            end else begin
                case (state)
                    S_HUNT: if (acc && rx_data == SYNC) state <= S_ADDR;
                    S_ADDR: if (acc) begin
                        addr <= rx_data;
                        sum <= rx_data;
                        state <= S_LEN;
                    end
                    S_LEN: if (acc) begin
                        len <= rx_data;
                        sum <= sum + rx_data;
                        idx <= 8'd0;
                        if (rx_data > 8'(MAX_LEN)) begin
                            pkt_err <= 1'b1;
                            err_cnt <= sat_inc(err_cnt);
                            state <= S_HUNT;
                        end else state <= rx_data == 8'd0 ? S_CHK : S_DATA;
                    end
                    S_DATA: if (acc) begin
                        sum <= sum + rx_data;
                        idx <= idx + 8'd1;
                        if (last) state <= S_CHK;
                    end
                    S_CHK: if (acc) begin
                        if (!chk_ok) begin
                            pkt_err <= 1'b1;
                            err_cnt <= sat_inc(err_cnt);
                            state <= S_HUNT;
                        end else if (len == 8'd0) begin
                            pkt_ok <= 1'b1;
                            state <= S_HUNT;
                        end else begin
                            state <= S_COMMIT;
                            rx_ready <= 1'b0;
                            wr_en <= 1'b1;
                            wr_addr <= addr;
                            idx <= 8'd0;
                            pkt_ok <= len == 8'd1;
                        end
                    end
                    S_COMMIT: if (last) begin
                        state <= S_HUNT;
                        rx_ready <= 1'b1;
                    end else begin
                        wr_en <= 1'b1;
                        wr_addr <= wr_addr + 8'd1;
                        idx <= idx + 8'd1;
                        pkt_ok <= idx + 8'd2 == len;
                    end
                    default: state <= S_HUNT;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ft_pkt_parser.sv
// tb_ft_pkt_parser: scoreboard bench for ft_pkt_parser (directed frames, random frames, overrun, reset, saturation)
module tb_ft_pkt_parser;
`ifdef FT_PKT_TIMEOUT_EN
    localparam int TO = 8;
    localparam int GAP = 7;
`else
    localparam int TO = 65535;
    localparam int GAP = 20;
`endif
    logic clk = 1'b0;
    logic reset_n, rx_valid, rx_ready, wr_en, pkt_ok, pkt_err, ovr;
    logic [7:0] rx_data, wr_addr, wr_data, err_cnt;
    logic [7:0] tx[$];
    logic [16:0] exp_wr[$];
    logic [3:0] exp_ev[$];
    int n_cmp = 0, n_bad = 0, ovr_cnt = 0, exp_errs = 0;

    ft_pkt_parser #(.MAX_LEN(16), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset_n(reset_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .pkt_ok(pkt_ok), .pkt_err(pkt_err), .ovr(ovr), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic put(input logic [7:0] b);
        rx_data = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1 rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic flush();
        while (tx.size() != 0) put(tx.pop_front());
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        exp_wr.push_back({1'b0, a, d});
    endtask

    task automatic err_ev();
        exp_ev.push_back(4'b0010);
        exp_errs++;
    endtask

    task automatic rand_frame(input int n, input bit bad);
        logic [7:0] a, s, d;
        a = 8'($urandom);
        s = a + 8'(n);
        tx = '{8'hA5, a, 8'(n)};
        for (int i = 0; i < n; i++) begin
            d = 8'($urandom);
            s = s + d;
            tx.push_back(d);
            if (!bad) wr(a + 8'(i), d);
        end
        tx.push_back(bad ? s ^ 8'h01 : s);
        if (bad) err_ev();
        else exp_ev.push_back(n > 0 ? 4'b0101 : 4'b0001);
        flush();
        idle(n + 3);
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            if (ovr) ovr_cnt++;
            if (wr_en) chk("write", {1'b0, wr_addr, wr_data}, exp_wr.size() != 0 ? exp_wr.pop_front() : 17'h10000);
            if (pkt_ok || pkt_err) chk("event", {1'b0, wr_en, pkt_err, pkt_ok}, exp_ev.size() != 0 ? exp_ev.pop_front() : 4'b1000);
        end
    end

    initial begin
        reset_n = 1'b0;
        rx_valid = 1'b0;
        rx_data = 8'h00;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", rx_ready, 1);
        chk("rst_outs", {wr_en, pkt_ok, pkt_err, ovr}, 0);
        chk("rst_wr", {wr_addr, wr_data}, 0);
        chk("rst_errcnt", err_cnt, 0);
        @(posedge clk);
        #1;
        // basic 3-byte commit
        tx = '{8'hA5, 8'h10, 8'h03, 8'h11, 8'h22, 8'h33, 8'h79};
        wr(8'h10, 8'h11); wr(8'h11, 8'h22); wr(8'h12, 8'h33);
        exp_ev.push_back(4'b0101);
        flush();
        idle(6);
        chk("s1_left", exp_wr.size() + exp_ev.size(), 0);
        chk("s1_hold", {wr_en, wr_addr, wr_data}, {1'b0, 8'h12, 8'h33});
        // address wrap
        tx = '{8'hA5, 8'hFE, 8'h03, 8'h01, 8'h02, 8'h03, 8'h07};
        wr(8'hFE, 8'h01); wr(8'hFF, 8'h02); wr(8'h00, 8'h03);
        exp_ev.push_back(4'b0101);
        flush();
        idle(6);
        chk("s2_left", exp_wr.size() + exp_ev.size(), 0);
        // bad checksum
        tx = '{8'hA5, 8'h10, 8'h02, 8'hAA, 8'hBB, 8'h00};
        err_ev();
        flush();
        idle(4);
        chk("s3_errcnt", err_cnt, 1);
        // LEN over limit, then zero-length frame
        tx = '{8'hA5, 8'h20, 8'h11};
        err_ev();
        flush();
        idle(2);
        chk("s4_errcnt", err_cnt, 2);
        tx = '{8'hA5, 8'h20, 8'h00, 8'h20};
        exp_ev.push_back(4'b0001);
        flush();
        idle(4);
        chk("s4_left", exp_wr.size() + exp_ev.size(), 0);
        // SYNC value inside payload is plain data
        tx = '{8'h5A, 8'hA5, 8'h60, 8'h02, 8'hA5, 8'hA5, 8'hAC};
        wr(8'h60, 8'hA5); wr(8'h61, 8'hA5);
        exp_ev.push_back(4'b0101);
        flush();
        idle(5);
        chk("s5_left", exp_wr.size() + exp_ev.size(), 0);
        // valid held high through COMMIT: three drops, writes intact
        ovr_cnt = 0;
        tx = '{8'hA5, 8'h30, 8'h03, 8'h01, 8'h02, 8'h03, 8'h39, 8'h00, 8'h00, 8'h00};
        wr(8'h30, 8'h01); wr(8'h31, 8'h02); wr(8'h32, 8'h03);
        exp_ev.push_back(4'b0101);
        flush();
        idle(4);
        chk("s6_ovr", ovr_cnt, 3);
        chk("s6_left", exp_wr.size() + exp_ev.size(), 0);
        chk("s6_ready", rx_ready, 1);
        // random frames including max length and zero length
        rand_frame(16, 0);
        rand_frame(0, 0);
        rand_frame(1, 0);
        for (int i = 0; i < 5; i++) rand_frame(int'($urandom_range(1, 16)), i == 2);
        chk("rand_left", exp_wr.size() + exp_ev.size(), 0);
        chk("rand_errcnt", err_cnt, 32'(exp_errs));
        // idle gap inside a frame that must not abort it
        put(8'hA5);
        idle(GAP);
        put(8'h70);
        idle(GAP);
        put(8'h01);
        idle(GAP);
        put(8'h42);
        idle(GAP);
        put(8'hB3);
        wr(8'h70, 8'h42);
        exp_ev.push_back(4'b0101);
        idle(4);
        chk("gap_left", exp_wr.size() + exp_ev.size(), 0);
`ifdef FT_PKT_TIMEOUT_EN
        tx = '{8'hA5, 8'h10};
        err_ev();
        flush();
        idle(10);
        chk("to_left", exp_ev.size(), 0);
        chk("to_errcnt", err_cnt, 32'(exp_errs));
`endif
        // reset in the middle of the payload
        tx = '{8'hA5, 8'h40, 8'h04, 8'h01, 8'h02};
        flush();
        reset_n = 1'b0;
        idle(1);
        reset_n = 1'b1;
        exp_errs = 0;
        @(negedge clk);
        chk("mid_rst", {rx_ready, wr_en, pkt_err, err_cnt}, {1'b1, 1'b0, 1'b0, 8'h00});
        @(posedge clk);
        #1;
        tx = '{8'hA5, 8'h50, 8'h01, 8'h09, 8'h5A};
        wr(8'h50, 8'h09);
        exp_ev.push_back(4'b0101);
        flush();
        idle(4);
        chk("post_rst_left", exp_wr.size() + exp_ev.size(), 0);
        // error counter saturation
        for (int i = 0; i < 260; i++) begin
            tx = '{8'hA5, 8'h00, 8'h11};
            err_ev();
            flush();
        end
        idle(3);
        chk("sat_errcnt", err_cnt, 8'hFF);
        chk("sat_left", exp_ev.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ft_pkt_parser.md
FT_PKT_PARSER -- requirements
Module: ft_pkt_parser

Interface
REQ-001 Parameter MAX_LEN, default 16: maximum payload bytes per frame (1..16).
REQ-002 Parameter TIMEOUT_CYCLES, default 65535: inter-byte idle limit inside a frame, in CLK cycles.
REQ-003 CLK  input  1  single clock, shared with the FTDI sync-FIFO reader stage feeding this block.
REQ-004 RESET_N  input  1  reset; synchronous and active-low.
REQ-005 RX_DATA  input  8  received byte from the reader stage.
REQ-006 RX_VALID  input  1  one-cycle strobe; RX_DATA valid this cycle.
REQ-007 RX_READY  output  1  high when a byte is accepted; the reader gates its FT_RD with it.
REQ-008 WR_EN  output  1  register-write strobe.
REQ-009 WR_ADDR  output  8  write address.
REQ-010 WR_DATA  output  8  write data.
REQ-011 PKT_OK  output  1  one-cycle pulse: frame committed.
REQ-012 PKT_ERR  output  1  one-cycle pulse: frame discarded.
REQ-013 OVR  output  1  one-cycle pulse: byte dropped because RX_READY was low.
REQ-014 ERR_CNT  output  8  saturating count of PKT_ERR events.

Function
REQ-015 Frame format: SYNC (0xA5), ADDR, LEN, LEN payload bytes, CHK.
REQ-016 CHK is valid when it equals the 8-bit modulo-256 sum of ADDR, LEN and all payload bytes.
REQ-017 FSM states: HUNT, ADDR, LEN, DATA, CHK, COMMIT.
REQ-018 A byte is accepted only on a cycle where RX_VALID=1 and RX_READY=1.
REQ-019 Transitions:
- HUNT->ADDR on accepted 0xA5; any other byte is ignored without error.
- ADDR->LEN on accepted byte.
- LEN->DATA if 0<LEN<=MAX_LEN; LEN->CHK if LEN=0.
- LEN>MAX_LEN: PKT_ERR, then HUNT.
REQ-020 DATA: each accepted byte is stored at index 0..LEN-1; the last byte moves the FSM to CHK. 0xA5 inside the payload is data.
REQ-021 CHK match with LEN>0: COMMIT. CHK match with LEN=0: PKT_OK next cycle, then HUNT. CHK mismatch: PKT_ERR next cycle, then HUNT, no writes.
REQ-022 COMMIT: WR_EN high for exactly LEN consecutive cycles, starting the cycle after CHK acceptance.
- WR_ADDR = ADDR+i modulo 256 (wraps 0xFF->0x00); WR_DATA = payload[i].
- PKT_OK pulses together with the final WR_EN; the FSM then enters HUNT.
REQ-023 RX_READY=0 in COMMIT only; =1 in all other states.
REQ-024 RX_VALID=1 while RX_READY=0: byte dropped, OVR pulses the same cycle, FSM unaffected.
REQ-025 Outputs are registered. WR_ADDR/WR_DATA are don't-care while WR_EN=0 but shall hold their last values.
REQ-026 ERR_CNT increments on each PKT_ERR and saturates at 0xFF.

Reset
REQ-027 On RESET_N=0 at a CLK edge, the following are cleared:
- FSM to HUNT.
- WR_EN, PKT_OK, PKT_ERR, OVR to 0.
- WR_ADDR, WR_DATA, ERR_CNT, checksum accumulator, byte index to 0.
- RX_READY to 1.
REQ-028 Reset mid-frame or mid-COMMIT aborts with no further writes and no PKT_ERR; payload buffer contents need not be cleared.

Configuration
REQ-029 Macro FT_PKT_TIMEOUT_EN defined:
- An idle counter runs in ADDR, LEN, DATA and CHK, cleared on every accepted byte.
- On reaching TIMEOUT_CYCLES: PKT_ERR, then HUNT.
- A byte accepted in the same cycle as expiry wins; no timeout occurs.
REQ-030 Macro FT_PKT_TIMEOUT_EN undefined: no idle counter; the FSM waits indefinitely mid-frame; TIMEOUT_CYCLES is unused.

Structure
REQ-031 Package ft_pkt_pkg holds the state enum, the SYNC constant 0xA5 and MAX_LEN_LIMIT=16.
REQ-032 Payload storage is sub-module ft_pkt_buf: MAX_LEN x 8 register file, one write port, one read port, read data registered.

Verification
REQ-033 Bench shall cover these directed scenarios:
- A5 10 03 11 22 33 79 -> WR_EN 3 cycles: (10,11),(11,22),(12,33); PKT_OK with the third write.
- A5 FE 03 01 02 03 07 -> writes to FE, FF, 00 (address wrap); PKT_OK.
- A5 10 02 AA BB 00 -> no WR_EN; PKT_ERR; ERR_CNT=1.
- A5 20 11 -> PKT_ERR immediately (LEN>MAX_LEN); then A5 20 00 20 -> PKT_OK, no writes.
- Valid 3-byte frame with RX_VALID held high during COMMIT -> 3 OVR pulses, writes intact.
- FT_PKT_TIMEOUT_EN defined, TIMEOUT_CYCLES=8: A5 10 then 8 idle cycles -> PKT_ERR, HUNT. Also RESET_N low mid-DATA -> HUNT, no writes.
